// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Master drives the request; slave returns grant and the response beat.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding,
// fills the IF/ID register and flushes wrong-path work on EX redirects.
//
// state  | meaning
// S_REQ  | request pc to imem (suppressed while IF/ID is stalled and full)
// S_WAIT | request accepted, awaiting the response beat
// S_HOLD | response buffered because IF/ID is blocked by decode
// S_DROP | wrong-path response still in flight, discard it on arrival
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target_pc,
  fetch_unit_if.master    imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     hold_buf;

  logic redir;
  logic blocked;
  logic accept;

  assign redir   = (is_branch & branch_taken) | jump;
  assign blocked = stall & if_valid;
  assign accept  = imem.imem_req & imem.imem_gnt;

  // Gated by rst_n so no request escapes while reset is held.
  assign imem.imem_req  = rst_n & (state == S_REQ) & ~blocked;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
      misaligned <= 1'b0;
      hold_buf   <= '0;
    end else begin
      misaligned <= 1'b0;
      if (redir) begin
        // A misaligned target keeps the old pc but still flushes the pipe.
        if (target_pc[1:0] == 2'b00) pc <= target_pc;
        else                         misaligned <= 1'b1;
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
        hold_buf <= '0;
        case (state)
          S_REQ:   state <= accept ? S_DROP : S_REQ;
          S_WAIT:  state <= imem.imem_rvalid ? S_REQ : S_DROP;
          S_DROP:  state <= imem.imem_rvalid ? S_REQ : S_DROP;
          default: state <= S_REQ;
        endcase
      end else begin
        if (!stall) if_valid <= 1'b0;
        case (state)
          S_REQ: begin
            if (accept) state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem.imem_rvalid) begin
              if (blocked) begin
                hold_buf <= imem.imem_rdata;
                state    <= S_HOLD;
              end else begin
                if_pc    <= pc;
                if_instr <= imem.imem_rdata;
                if_valid <= 1'b1;
                pc       <= pc + XLEN'(4);
                state    <= S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              if_pc    <= pc;
              if_instr <= hold_buf;
              if_valid <= 1'b1;
              pc       <= pc + XLEN'(4);
              state    <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem.imem_rvalid) state <= S_REQ;
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected IF/ID
// loads, a monitor pops and compares each new load; imem responds addr+0x1000_0000.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] target_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misaligned;

  fetch_unit_if #(.XLEN(32)) imem_bus ();

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .target_pc    (target_pc),
    .imem         (imem_bus.master),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_seen = 0;
  int granted = 0;
  int accepted = 0;
  int lat = 1;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] instr);
    exp_pc_q.push_back(p);
    exp_instr_q.push_back(instr);
  endtask

  task automatic grant(input int n);
    granted += n;
  endtask

  task automatic wait_seen(input string name, input int target);
    for (int i = 0; i < 60; i++) begin
      if (n_seen >= target) break;
      @(negedge clk);
    end
    tests++;
    if (n_seen < target) begin
      fails++;
      $display("FAIL %s: timeout, got %0d loads expected %0d", name, n_seen, target);
    end
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req && imem_bus.imem_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: timeout waiting for request acceptance", name);
    end
  endtask

  // imem model: samples acceptance away from the edge, answers after lat cycles.
  initial begin : imem_model
    logic        acc;
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    bit          busy;
    int          cnt;
    busy = 1'b0;
    cnt = 0;
    b_addr = '0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = rst_n && imem_bus.imem_req && imem_bus.imem_gnt;
      a_addr = imem_bus.imem_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        imem_bus.imem_rvalid = 1'b0;
        busy = 1'b0;
        accepted = granted;
        imem_bus.imem_gnt = 1'b0;
      end else begin
        imem_bus.imem_rvalid = 1'b0;
        if (busy) begin
          if (cnt <= 1) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata = b_addr + 32'h1000_0000;
            busy = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (acc) begin
          accepted++;
          if (lat <= 1) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata = a_addr + 32'h1000_0000;
          end else begin
            busy = 1'b1;
            cnt = lat - 1;
            b_addr = a_addr;
          end
        end
        imem_bus.imem_gnt = (granted > accepted);
      end
    end
  end

  // Monitor: a new IF/ID load is a valid cycle not preceded by a held (stalled) one.
  initial begin : monitor
    bit          held;
    logic [31:0] ep;
    logic [31:0] ei;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (if_valid && !held) begin
          if (exp_pc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_load: got pc %h instr %h, expected no load", if_pc, if_instr);
          end else begin
            ep = exp_pc_q.pop_front();
            ei = exp_instr_q.pop_front();
            check("load_pc", if_pc, ep);
            check("load_instr", if_instr, ei);
          end
          n_seen++;
        end
        held = stall && if_valid;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // reset values while rst_n is low
    #1 rst_n = 1'b0;
    #2;
    check("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: sequential fetch 0,4,8
    grant(3);
    push(32'h0000_0000, 32'h1000_0000);
    push(32'h0000_0004, 32'h1000_0004);
    push(32'h0000_0008, 32'h1000_0008);
    wait_seen("seq_loads", 3);
    step();
    step();
    @(negedge clk);
    check("seq_valid_drops", 32'(if_valid), 32'd0);
    check("seq_next_addr", imem_bus.imem_addr, 32'h0000_000C);
    check("seq_req_idle", 32'(imem_bus.imem_req), 32'd1);

    // 2: stall holds IF/ID and blocks new requests; release continues in order
    step();
    stall = 1'b1;
    grant(2);
    push(32'h0000_000C, 32'h1000_000C);
    push(32'h0000_0010, 32'h1000_0010);
    wait_seen("stall_first", 4);
    repeat (3) @(negedge clk);
    check("stall_hold_valid", 32'(if_valid), 32'd1);
    check("stall_hold_pc", if_pc, 32'h0000_000C);
    check("stall_no_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    stall = 1'b0;
    wait_seen("stall_release", 5);

    // 3: taken branch while in S_WAIT drops the in-flight response
    lat = 3;
    grant(1);
    wait_accept("br_accept");
    step();
    is_branch = 1'b1;
    branch_taken = 1'b1;
    target_pc = 32'h0000_0100;
    step();
    is_branch = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    check("br_flush_valid", 32'(if_valid), 32'd0);
    check("br_drop_no_req", 32'(imem_bus.imem_req), 32'd0);
    check("br_new_addr", imem_bus.imem_addr, 32'h0000_0100);
    lat = 1;
    grant(1);
    push(32'h0000_0100, 32'h1000_0100);
    wait_seen("br_target_load", 6);

    // 4: misaligned jump while stalled: pulse, pc kept, IF/ID flushed
    step();
    stall = 1'b1;
    grant(1);
    push(32'h0000_0104, 32'h1000_0104);
    wait_seen("mis_pre_load", 7);
    step();
    jump = 1'b1;
    target_pc = 32'h0000_0202;
    step();
    jump = 1'b0;
    @(negedge clk);
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_flush_valid", 32'(if_valid), 32'd0);
    check("mis_flush_instr", if_instr, NOP);
    check("mis_pc_kept", imem_bus.imem_addr, 32'h0000_0108);
    @(negedge clk);
    check("mis_one_cycle", 32'(misaligned), 32'd0);
    step();
    stall = 1'b0;

    // 5: not-taken branch is ignored; redirect under stall still flushes
    step();
    is_branch = 1'b1;
    branch_taken = 1'b0;
    target_pc = 32'h0000_0300;
    grant(2);
    push(32'h0000_0108, 32'h1000_0108);
    push(32'h0000_010C, 32'h1000_010C);
    wait_seen("nt_loads", 9);
    step();
    is_branch = 1'b0;
    step();
    stall = 1'b1;
    grant(1);
    push(32'h0000_0110, 32'h1000_0110);
    wait_seen("stall_br_pre", 10);
    step();
    is_branch = 1'b1;
    branch_taken = 1'b1;
    target_pc = 32'h0000_0040;
    step();
    is_branch = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    check("stall_br_flush", 32'(if_valid), 32'd0);
    check("stall_br_addr", imem_bus.imem_addr, 32'h0000_0040);
    step();
    stall = 1'b0;
    grant(1);
    push(32'h0000_0040, 32'h1000_0040);
    wait_seen("stall_br_load", 11);

    // redirect in the same cycle the request is granted -> S_DROP
    grant(1);
    wait_accept("gnt_br_accept");
    is_branch = 1'b1;
    branch_taken = 1'b1;
    target_pc = 32'h0000_0080;
    step();
    is_branch = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    check("gnt_br_drop_no_req", 32'(imem_bus.imem_req), 32'd0);
    check("gnt_br_addr", imem_bus.imem_addr, 32'h0000_0080);
    grant(1);
    push(32'h0000_0080, 32'h1000_0080);
    wait_seen("gnt_br_load", 12);

    // PC wrap at the top of the address space
    step();
    jump = 1'b1;
    target_pc = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    @(negedge clk);
    check("wrap_no_mis", 32'(misaligned), 32'd0);
    check("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    grant(2);
    push(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    push(32'h0000_0000, 32'h1000_0000);
    wait_seen("wrap_loads", 14);

    // 6: asynchronous reset in the middle of S_WAIT
    grant(1);
    push(32'h0000_0004, 32'h1000_0004);
    wait_seen("prerst_load", 15);
    lat = 3;
    grant(1);
    wait_accept("rst_accept");
    step();
    rst_n = 1'b0;
    #1;
    check("arst_imem_req", 32'(imem_bus.imem_req), 32'd0);
    check("arst_if_valid", 32'(if_valid), 32'd0);
    check("arst_if_pc", if_pc, 32'h0);
    check("arst_if_instr", if_instr, NOP);
    check("arst_misaligned", 32'(misaligned), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    lat = 1;
    grant(1);
    push(32'h0000_0000, 32'h1000_0000);
    wait_accept("post_rst_accept");
    check("post_rst_addr", imem_bus.imem_addr, 32'h0000_0000);
    wait_seen("post_rst_load", 16);

    repeat (5) step();
    check("queue_empty", 32'(exp_pc_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
